// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - shared capture-path types and constants
//
// Purpose: state encoding of the ADC write controller and the default
// per-buffer sample count, which the read controller also uses to size
// its bursts.

package adc_capture_pkg;

    localparam int SAMPLES_PER_BUF_DEF = 8192;
    localparam int ADC_DATA_W_DEF      = 16;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        ARMED = 5'b00010,
        FILL1 = 5'b00100,
        FILL2 = 5'b01000,
        DONE  = 5'b10000
    } state_type;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - registered rising-edge detector
//
// Purpose: flags the cycle in which sig_i goes from 0 to 1. The history
// register runs in every cycle so a level held before arming never
// counts as an edge.
//
// Ports:
//   clk    - clock
//   rstn   - synchronous active-low reset
//   sig_i  - level input
//   rise_o - high for one cycle on a 0->1 transition of sig_i

module edge_detect (
    input  logic clk,
    input  logic rstn,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/adc_write_controller.sv
// rtl/adc_write_controller.sv - triggered ADC capture into two ping-pong FIFOs
//
// Purpose: after arm (both FIFOs empty) and a qualified trigger rising
// edge, writes SAMPLES_PER_BUF samples into FIFO1, then into FIFO2, then
// holds full until the reader has drained both FIFOs.
//
// Ports:
//   clk, rstn           - clock, synchronous active-low reset
//   arm, abort          - capture request / return to idle
//   trig                - trigger level (rising edge qualifies)
//   adc_data, adc_valid - sample stream
//   full1/2, empty1/2   - FIFO status flags
//   wr_en1/2, wr_data   - registered FIFO write port (shared data)
//   full                - capture complete, both buffers ready
//   busy                - capture in progress or waiting for drain
//   overflow            - sticky: a sample was dropped on a full FIFO

module adc_write_controller
    import adc_capture_pkg::*;
#(
    parameter int DATA_W          = ADC_DATA_W_DEF,
    parameter int SAMPLES_PER_BUF = SAMPLES_PER_BUF_DEF,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              full1,
    input  logic              full2,
    input  logic              empty1,
    input  logic              empty2,
    output logic              wr_en1,
    output logic              wr_en2,
    output logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              busy,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_BUF - 1);

    state_type         state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_en1_q, wr_en1_d;
    logic              wr_en2_q, wr_en2_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              overflow_q, overflow_d;
    logic              full_q;
    logic              trig_rise;

    edge_detect u_trig_edge (
        .clk    (clk),
        .rstn   (rstn),
        .sig_i  (trig),
        .rise_o (trig_rise)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_en1_d   = 1'b0;
        wr_en2_d   = 1'b0;
        wr_data_d  = wr_data_q;
        overflow_d = overflow_q;

        if (abort) begin
            // A strobe already in wr_enX_q still goes out this cycle;
            // only new acceptances are suppressed.
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arm && empty1 && empty2) begin
                        state_d    = ARMED;
                        overflow_d = 1'b0;
                    end
                end
                ARMED: begin
                    if (trig_rise && adc_valid) begin
                        wr_en1_d  = 1'b1;
                        wr_data_d = adc_data;
                        count_d   = CNT_W'(1);
                        state_d   = FILL1;
                    end
                end
                FILL1: begin
                    if (adc_valid) begin
                        if (full1) begin
                            // Dropped sample is not redirected to FIFO2.
                            overflow_d = 1'b1;
                            count_d    = '0;
                            state_d    = FILL2;
                        end else begin
                            wr_en1_d  = 1'b1;
                            wr_data_d = adc_data;
                            if (count_q == LAST_CNT) begin
                                count_d = '0;
                                state_d = FILL2;
                            end else begin
                                count_d = count_q + 1'b1;
                            end
                        end
                    end
                end
                FILL2: begin
                    if (adc_valid) begin
                        if (full2) begin
                            overflow_d = 1'b1;
                            count_d    = '0;
                            state_d    = DONE;
                        end else begin
                            wr_en2_d  = 1'b1;
                            wr_data_d = adc_data;
                            if (count_q == LAST_CNT) begin
                                count_d = '0;
                                state_d = DONE;
                            end else begin
                                count_d = count_q + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (empty1 && empty2) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            count_q    <= '0;
            wr_en1_q   <= 1'b0;
            wr_en2_q   <= 1'b0;
            wr_data_q  <= '0;
            overflow_q <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_en1_q   <= wr_en1_d;
            wr_en2_q   <= wr_en2_d;
            wr_data_q  <= wr_data_d;
            overflow_q <= overflow_d;
            // Registered from the next state so full tracks DONE exactly,
            // never asserting in ARMED.
            full_q     <= (state_d == DONE);
        end
    end

    assign wr_en1   = wr_en1_q;
    assign wr_en2   = wr_en2_q;
    assign wr_data  = wr_data_q;
    assign full     = full_q;
    assign busy     = (state_q != IDLE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_adc_write_controller.sv
// tb/tb_adc_write_controller.sv - scoreboard bench for adc_write_controller

module tb_adc_write_controller;

    localparam int DW  = 16;
    localparam int SPB = 4;

    logic          clk = 1'b0;
    logic          rstn, arm, abort, trig, adc_valid;
    logic [DW-1:0] adc_data;
    logic          full1, full2, empty1, empty2;
    logic          wr_en1, wr_en2, full, busy, overflow;
    logic [DW-1:0] wr_data;

    always #5 clk = ~clk;

    adc_write_controller #(
        .DATA_W          (DW),
        .SAMPLES_PER_BUF (SPB),
        .CNT_W           (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .arm       (arm),
        .abort     (abort),
        .trig      (trig),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .full1     (full1),
        .full2     (full2),
        .empty1    (empty1),
        .empty2    (empty2),
        .wr_en1    (wr_en1),
        .wr_en2    (wr_en2),
        .wr_data   (wr_data),
        .full      (full),
        .busy      (busy),
        .overflow  (overflow)
    );

    typedef struct packed {
        logic          full;
        logic          busy;
        logic          ovf;
        logic [DW-1:0] wd;
    } st_t;

    st_t         st_q[$];
    logic [DW:0] wr_q[$];   // {fifo2_sel, data}
    int checks   = 0;
    int failures = 0;

    // Reference model: capture phase plus slots left in the current buffer.
    localparam int M_IDLE = 0, M_ARMED = 1, M_BUF1 = 2, M_BUF2 = 3, M_DONE = 4;
    int            m_phase     = M_IDLE;
    int            m_left      = 0;
    logic          m_ovf       = 1'b0;
    logic          m_trig_prev = 1'b0;
    logic [DW-1:0] m_wd        = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void accept(input logic to_fifo2);
        m_wd = adc_data;
        wr_q.push_back({to_fifo2, adc_data});
    endfunction

    function automatic void next_buf();
        if (m_phase == M_BUF1) begin
            m_phase = M_BUF2;
            m_left  = SPB;
        end else begin
            m_phase = M_DONE;
        end
    endfunction

    function automatic void model_cycle();
        logic rise;
        logic blocked;
        st_t  s;
        rise = trig && !m_trig_prev;
        if (!rstn) begin
            m_phase = M_IDLE; m_left = 0; m_ovf = 1'b0; m_wd = '0; m_trig_prev = 1'b0;
        end else begin
            m_trig_prev = trig;
            if (abort) begin
                m_phase = M_IDLE;
            end else begin
                case (m_phase)
                    M_IDLE:  if (arm && empty1 && empty2) begin m_phase = M_ARMED; m_ovf = 1'b0; end
                    M_ARMED: if (rise && adc_valid) begin accept(1'b0); m_left = SPB - 1; m_phase = M_BUF1; end
                    M_BUF1, M_BUF2: begin
                        if (adc_valid) begin
                            blocked = (m_phase == M_BUF1) ? full1 : full2;
                            if (blocked) begin
                                m_ovf = 1'b1;
                                next_buf();
                            end else begin
                                accept(m_phase == M_BUF2);
                                m_left--;
                                if (m_left == 0) next_buf();
                            end
                        end
                    end
                    M_DONE:  if (empty1 && empty2) m_phase = M_IDLE;
                    default: ;
                endcase
            end
        end
        s.full = (m_phase == M_DONE);
        s.busy = (m_phase != M_IDLE);
        s.ovf  = m_ovf;
        s.wd   = m_wd;
        st_q.push_back(s);
    endfunction

    // Monitor: every DUT write must match the head of the expected queue.
    always @(negedge clk) begin
        st_t         s;
        logic [DW:0] w;
        if (wr_en1 || wr_en2) begin
            if (wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: wr_en1=%0b wr_en2=%0b data=%0h expected none at %0t",
                         wr_en1, wr_en2, wr_data, $time);
            end else begin
                w = wr_q.pop_front();
                check("wr_select", 32'({wr_en2, wr_en1}), w[DW] ? 32'h2 : 32'h1);
                check("wr_data_on_write", 32'(wr_data), 32'(w[DW-1:0]));
            end
        end
        if (st_q.size() != 0) begin
            s = st_q.pop_front();
            check("full", 32'(full), 32'(s.full));
            check("busy", 32'(busy), 32'(s.busy));
            check("overflow", 32'(overflow), 32'(s.ovf));
            check("wr_data_hold", 32'(wr_data), 32'(s.wd));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_cycle();
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic t);
        adc_valid = v;
        adc_data  = d;
        trig      = t;
        tick();
    endtask

    task automatic do_arm();
        empty1 = 1'b1; empty2 = 1'b1; arm = 1'b1;
        drive(1'b0, 16'($urandom), 1'b0);
        arm = 1'b0; empty1 = 1'b0; empty2 = 1'b0;
    endtask

    task automatic drain();
        repeat (2) drive(1'b0, 16'($urandom), 1'b0);
        empty1 = 1'b1;
        repeat (3) drive(1'b0, 16'($urandom), 1'b0);
        empty2 = 1'b1;
        repeat (2) drive(1'b0, 16'($urandom), 1'b0);
        check("queue_drained", 32'(wr_q.size()), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0; adc_valid = 1'b0;
        adc_data = '0; full1 = 1'b0; full2 = 1'b0; empty1 = 1'b1; empty2 = 1'b1;
        tick(); tick();
        rstn = 1'b1;
        tick();

        // Clean capture 1..8
        do_arm();
        for (int i = 1; i <= 8; i++) drive(1'b1, 16'(i), 1'b1);
        drain();

        // Gapped valid
        do_arm();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 16'(i), 1'b1);
            drive(1'b0, 16'($urandom), 1'b1);
        end
        drain();

        // Arm blocked by non-empty FIFO2, then trig held high across arming
        empty1 = 1'b1; empty2 = 1'b0; arm = 1'b1;
        drive(1'b0, 16'h0, 1'b0);
        arm = 1'b0;
        drive(1'b0, 16'h0, 1'b1);
        empty2 = 1'b1; arm = 1'b1;
        drive(1'b1, 16'($urandom), 1'b1);
        arm = 1'b0; empty1 = 1'b0; empty2 = 1'b0;
        repeat (3) drive(1'b1, 16'($urandom), 1'b1);
        drive(1'b1, 16'($urandom), 1'b0);
        drive(1'b1, 16'($urandom), 1'b1);
        for (int c = 0; c < 100 && m_phase != M_DONE; c++)
            drive(1'($urandom_range(0, 1)), 16'($urandom), 1'b1);
        drain();

        // FIFO1 full on the 3rd sample
        do_arm();
        for (int i = 1; i <= 7; i++) begin
            full1 = (i == 3);
            drive(1'b1, 16'(i), 1'b1);
        end
        full1 = 1'b0;
        drain();

        // New arm clears overflow; abort after two FIFO1 writes
        do_arm();
        drive(1'b1, 16'h0001, 1'b1);
        drive(1'b1, 16'h0002, 1'b1);
        abort = 1'b1;
        drive(1'b1, 16'h0003, 1'b1);
        abort = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 16'($urandom), 1'(i % 2));

        // Drop in FIFO1, abort in FILL2: overflow survives the abort
        do_arm();
        drive(1'b1, 16'($urandom), 1'b1);
        full1 = 1'b1;
        drive(1'b1, 16'($urandom), 1'b1);
        full1 = 1'b0;
        drive(1'b1, 16'($urandom), 1'b1);
        abort = 1'b1;
        drive(1'b1, 16'($urandom), 1'b1);
        abort = 1'b0;
        repeat (2) drive(1'b0, 16'($urandom), 1'b0);

        // Reset in FILL2 with overflow set
        do_arm();
        drive(1'b1, 16'($urandom), 1'b1);
        full1 = 1'b1;
        drive(1'b1, 16'($urandom), 1'b1);
        full1 = 1'b0;
        drive(1'b1, 16'($urandom), 1'b1);
        rstn = 1'b0;
        drive(1'b1, 16'($urandom), 1'b1);
        rstn = 1'b1;
        repeat (2) drive(1'b0, 16'($urandom), 1'b0);

        // Randomised captures: gaps, trigger chatter, sporadic full flags, stray arms
        for (int r = 0; r < 6; r++) begin
            do_arm();
            for (int c = 0; c < 200 && m_phase != M_DONE; c++) begin
                full1 = ($urandom_range(0, 15) == 0);
                full2 = ($urandom_range(0, 15) == 0);
                arm   = ($urandom_range(0, 7) == 0);
                drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 1)));
            end
            full1 = 1'b0; full2 = 1'b0; arm = 1'b0;
            drain();
        end

        drive(1'b0, 16'h0, 1'b0);
        @(negedge clk);
        #1;
        check("final_queue_empty", 32'(wr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_write_controller.md
Name: adc_write_controller

Overview:
- Capture-side controller that writes a triggered ADC sample stream into two ping-pong sample FIFOs.
- Fills FIFO1, then FIFO2, then asserts `full` so the downstream read/Ethernet controller drains both FIFOs.
- Re-arms only once both FIFOs are empty again, giving one clean frame per capture.

Parameters:
- DATA_W, 16, ADC sample width in bits.
- SAMPLES_PER_BUF, 8192, samples written into each FIFO per capture; legal range 2..65535.
- CNT_W, 16, width of the per-buffer sample counter; must satisfy 2^CNT_W > SAMPLES_PER_BUF.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, synchronous, active-low; clock clk.
- arm  in  1  single-cycle request to arm a capture.
- abort  in  1  synchronous abort; returns the block to IDLE.
- trig  in  1  trigger level; only its rising edge qualifies.
- adc_data  in  DATA_W  sample.
- adc_valid  in  1  adc_data valid this cycle.
- full1  in  1  FIFO1 full flag.
- full2  in  1  FIFO2 full flag.
- empty1  in  1  FIFO1 empty flag.
- empty2  in  1  FIFO2 empty flag.
- wr_en1  out  1  FIFO1 write strobe (registered).
- wr_en2  out  1  FIFO2 write strobe (registered).
- wr_data  out  DATA_W  FIFO write data (registered, shared by both FIFOs).
- full  out  1  capture complete; tells the reader both buffers are ready.
- busy  out  1  high in ARMED, FILL1, FILL2 and DONE.
- overflow  out  1  sticky; a sample was dropped because a FIFO was unexpectedly full.

Behaviour:
- Reset: state IDLE, count 0. Outputs wr_en1, wr_en2, full, busy and overflow are 0; wr_data is 0. Trigger edge register is 0.
- Trigger qualification: trig_rise = trig & ~trig_q, where trig_q is trig registered. trig_q keeps updating in every state, including IDLE.
- Write path latency: a sample accepted in cycle N appears as wr_data with wr_enX=1 in cycle N+1.
  - wr_data updates only on accepted samples and holds otherwise.
  - wr_en1 and wr_en2 are never high in the same cycle.
- IDLE:
  - arm=1 and empty1=1 and empty2=1 -> ARMED.
  - arm with either FIFO non-empty is ignored; no latching.
- ARMED (busy=1):
  - trig_rise=1 and adc_valid=1 -> accept this sample into FIFO1, set count=1, go to FILL1.
  - trig_rise with adc_valid=0 is ignored; the block keeps waiting for the next rising edge.
- FILL1, on each adc_valid cycle:
  - full1=0: write the sample and increment count. If the pre-increment count equals SAMPLES_PER_BUF-1 -> FILL2, count=0.
  - full1=1: drop the sample, set overflow=1, go to FILL2 with count=0. The dropped sample is not redirected to FIFO2.
  - adc_valid=0: nothing happens; the state holds.
- FILL2: same rules using full2 and wr_en2; the terminal transition goes to DONE with count=0.
- DONE (full=1, busy=1):
  - No writes.
  - empty1=1 and empty2=1 -> IDLE; full deasserts in the cycle IDLE is entered.
  - The reader always sees full high until it has drained both FIFOs.
- full is registered and equals (state==DONE). It also must not glitch high during ARMED.
- abort=1 in any state -> IDLE next cycle.
  - count is cleared.
  - A write strobe already registered for this cycle still completes.
  - overflow is not cleared.
- Precedence: abort > FIFO-full drop > normal write.
- arm=1 in any state other than IDLE is ignored.
- overflow clears only on reset, or on arm being accepted in IDLE.
- Total samples per clean capture: 2*SAMPLES_PER_BUF.

Decomposition:
- Package adc_capture_pkg holds:
  - state_type, one-hot: IDLE=5'b00001, ARMED=5'b00010, FILL1=5'b00100, FILL2=5'b01000, DONE=5'b10000.
  - The default SAMPLES_PER_BUF constant, shared with the read controller's burst constants.
- One natural sub-module: edge_detect (rising-edge detector on trig with its own rstn). Everything else stays in adc_write_controller.

Test Plan (SAMPLES_PER_BUF=4, DATA_W=16):
- Clean capture: with both FIFOs empty, pulse arm. Drive trig rising with adc_valid=1 and data 0x0001..0x0008 on consecutive cycles.
  - Expected: wr_en1 high for 0x0001-0x0004, then wr_en2 high for 0x0005-0x0008, each one cycle after input.
  - full rises the cycle after the 8th sample is accepted; overflow=0.
- Gapped valid: same as the clean capture, but adc_valid toggles 1,0,1,0.
  - Expected: exactly 4 writes per FIFO, no writes on gap cycles, identical data order.
- Arm blocked and trigger qualification: arm with empty2=0 leaves the block in IDLE (busy=0).
  - Then make both FIFOs empty, arm, and hold trig high from before arming. No capture occurs until trig goes low then high.
- FIFO full mid-fill: force full1=1 on the 3rd sample (0x0003).
  - Expected: 0x0003 is dropped and overflow=1. Next samples 0x0004-0x0007 go to FIFO2, then DONE.
- Drain handshake: in DONE, empty1=1, empty2=0 keeps full=1. Setting empty2=1 drops full next cycle and the block returns to IDLE.
  - A new arm then clears overflow.
- Abort and reset mid-fill: abort after 2 FIFO1 writes -> IDLE next cycle, full=0, no further writes.
  - Repeat with rstn=0 mid-FILL2. Every output returns to its reset value on the next clock.
